// File: rtl/window_gen3x3_pkg.sv
// Shared definitions for the 3x3 window generator and its consumers.
// Window packing: each row is {left (c-2), mid (c-1), right (c)}, with left in the MSB slice.
package window_gen3x3_pkg;

  localparam int WI_DEF    = 8;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;

  // Column slot inside a window row; slot order matches MSB-first packing.
  typedef enum logic [1:0] {
    SLOT_LEFT  = 2'd0,
    SLOT_MID   = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_e;

  // Counter width large enough to hold max(w, h) - 1.
  function automatic int cw_for(input int w, input int h);
    return $clog2((w > h) ? w : h);
  endfunction

endpackage

// File: rtl/window_gen3x3_if.sv
// Pixel-in / window-out stream bundle between a feature-map source, the
// window generator and a conv3x3 consumer.
interface window_gen3x3_if #(
  parameter int WI = window_gen3x3_pkg::WI_DEF
);

  logic              iInValid;
  logic [WI-1:0]     iPixel;
  logic              oOutValid;
  logic [3*WI-1:0]   oWindowOutRow1;
  logic [3*WI-1:0]   oWindowOutRow2;
  logic [3*WI-1:0]   oWindowOutRow3;
  logic              oFrameDone;

  // Pixel source / window sink side.
  modport master (
    output iInValid, iPixel,
    input  oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3, oFrameDone
  );

  // Window generator side.
  modport slave (
    input  iInValid, iPixel,
    output oOutValid, oWindowOutRow1, oWindowOutRow2, oWindowOutRow3, oFrameDone
  );

endinterface

// File: rtl/window_gen3x3_line_buffer.sv
// Single-line delay with enable: circular RAM, read-before-write at one pointer.
// dout is the value written DEPTH accepted samples ago.
module line_buffer #(
  parameter int WI    = 8,
  parameter int DEPTH = 28
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [WI-1:0] din,
  output logic [WI-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WI-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;

  assign dout = mem[ptr];

  // Storage write; contents are never reset, downstream row gating masks them.
  always_ff @(posedge clk) begin
    if (en) begin
      mem[ptr] <= din;
    end
  end

  // Circular pointer, advanced only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      if (ptr == PW'(DEPTH - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + PW'(1);
      end
    end
  end

endmodule

// File: rtl/window_gen3x3.sv
// Streaming 3x3 window generator: two line buffers feed the top/mid taps,
// a 3x3 shift register forms the window, counters gate valid output so only
// full no-padding windows are emitted.
module window_gen3x3
  import window_gen3x3_pkg::*;
#(
  parameter int WI    = WI_DEF,
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF,
  parameter int CW    = cw_for(IMG_W, IMG_H)
) (
  input  logic             iClk,
  input  logic             iRsn,
  window_gen3x3_if.slave   win
);

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          col_last;
  logic          row_last;
  logic          in_window;

  logic [WI-1:0] tap_mid;
  logic [WI-1:0] tap_top;

  // win_q[0] = top row (r-2), win_q[1] = middle (r-1), win_q[2] = bottom (r).
  logic [WI-1:0] win_q [3][3];

  logic out_valid;
  logic frame_done;

  assign col_last  = (col == CW'(IMG_W - 1));
  assign row_last  = (row == CW'(IMG_H - 1));
  assign in_window = (row >= CW'(2)) && (col >= CW'(2));

  // Line A delays the input by one line; line B delays line A's output by another.
  line_buffer #(.WI(WI), .DEPTH(IMG_W)) u_line_a (
    .clk   (iClk),
    .rst_n (iRsn),
    .en    (win.iInValid),
    .din   (win.iPixel),
    .dout  (tap_mid)
  );

  line_buffer #(.WI(WI), .DEPTH(IMG_W)) u_line_b (
    .clk   (iClk),
    .rst_n (iRsn),
    .en    (win.iInValid),
    .din   (tap_mid),
    .dout  (tap_top)
  );

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      col <= '0;
      row <= '0;
    end else if (win.iInValid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Window shift: columns move left, the new {top, mid, bottom} column enters right.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (win.iInValid) begin
      for (int unsigned r = 0; r < 3; r++) begin
        win_q[r][SLOT_LEFT] <= win_q[r][SLOT_MID];
        win_q[r][SLOT_MID]  <= win_q[r][SLOT_RIGHT];
      end
      win_q[0][SLOT_RIGHT] <= tap_top;
      win_q[1][SLOT_RIGHT] <= tap_mid;
      win_q[2][SLOT_RIGHT] <= win.iPixel;
    end
  end

  // Valid and frame-done flags, registered alongside the window they qualify.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      out_valid  <= win.iInValid && in_window;
      frame_done <= win.iInValid && row_last && col_last;
    end
  end

  // Output packing: left column in the MSB slice of each row.
  always_comb begin
    win.oOutValid      = out_valid;
    win.oFrameDone     = frame_done;
    win.oWindowOutRow1 = {win_q[0][SLOT_LEFT], win_q[0][SLOT_MID], win_q[0][SLOT_RIGHT]};
    win.oWindowOutRow2 = {win_q[1][SLOT_LEFT], win_q[1][SLOT_MID], win_q[1][SLOT_RIGHT]};
    win.oWindowOutRow3 = {win_q[2][SLOT_LEFT], win_q[2][SLOT_MID], win_q[2][SLOT_RIGHT]};
  end

endmodule

// File: tb/tb_window_gen3x3.sv
// Self-checking bench for window_gen3x3: three instances (4x4, 28x28, 3x3),
// a per-instance scoreboard built from a stored-image model, directed phases.
module tb_window_gen3x3;

  typedef struct packed {
    logic [23:0] r1;
    logic [23:0] r2;
    logic [23:0] r3;
    logic        done;
  } exp_t;

  logic clk;
  logic rst_n;
  logic rst4_n;

  int n_checks = 0;
  int n_err    = 0;

  window_gen3x3_if #(.WI(8)) if4  ();
  window_gen3x3_if #(.WI(8)) if28 ();
  window_gen3x3_if #(.WI(8)) if3  ();

  window_gen3x3 #(.WI(8), .IMG_W(4), .IMG_H(4)) u_dut4 (
    .iClk (clk), .iRsn (rst4_n), .win (if4)
  );
  window_gen3x3 #(.WI(8), .IMG_W(28), .IMG_H(28)) u_dut28 (
    .iClk (clk), .iRsn (rst_n), .win (if28)
  );
  window_gen3x3 #(.WI(8), .IMG_W(3), .IMG_H(3)) u_dut3 (
    .iClk (clk), .iRsn (rst_n), .win (if3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = 4x4, 1 = 28x28, 2 = 3x3.
  logic [7:0]  img [3][28][28];
  int          mr [3];
  int          mc [3];
  int          mw [3] = '{4, 28, 3};
  int          mh [3] = '{4, 28, 3};
  int          wins [3] = '{0, 0, 0};
  int          dones [3] = '{0, 0, 0};
  logic        acc [3];
  logic        hold_chk [3] = '{1'b0, 1'b0, 1'b0};
  logic [71:0] prev [3];
  exp_t        q0 [$];
  exp_t        q1 [$];
  exp_t        q2 [$];

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int qsize(input int id);
    case (id)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qpop(input int id);
    case (id)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic qpush(input int id, input exp_t e);
    case (id)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic model_reset(input int id);
    mr[id] = 0;
    mc[id] = 0;
  endtask

  // Store the accepted pixel; if it completes a window, queue the expected window.
  task automatic model_accept(input int id, input logic [7:0] p);
    int r, c;
    exp_t e;
    r = mr[id];
    c = mc[id];
    img[id][r][c] = p;
    if (r >= 2 && c >= 2) begin
      e.r1   = {img[id][r-2][c-2], img[id][r-2][c-1], img[id][r-2][c]};
      e.r2   = {img[id][r-1][c-2], img[id][r-1][c-1], img[id][r-1][c]};
      e.r3   = {img[id][r][c-2],   img[id][r][c-1],   img[id][r][c]};
      e.done = (r == mh[id] - 1) && (c == mw[id] - 1);
      qpush(id, e);
    end
    if (c == mw[id] - 1) begin
      mc[id] = 0;
      mr[id] = (r == mh[id] - 1) ? 0 : r + 1;
    end else begin
      mc[id] = c + 1;
    end
  endtask

  // One clock of stimulus for one instance; inputs change 1 time unit after the edge.
  task automatic drive(input int id, input logic v, input logic [7:0] p);
    case (id)
      0: begin if4.iInValid = v;  if4.iPixel = p;  end
      1: begin if28.iInValid = v; if28.iPixel = p; end
      default: begin if3.iInValid = v; if3.iPixel = p; end
    endcase
    @(posedge clk);
    if (v) model_accept(id, p);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      if4.iInValid = 1'b0;
      if28.iInValid = 1'b0;
      if3.iInValid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_out(input int id, input logic v, input logic d,
                           input logic [23:0] r1, input logic [23:0] r2, input logic [23:0] r3);
    exp_t e;
    int   sz;
    if (acc[id] === 1'b0) begin
      chk($sformatf("u%0d.valid_without_accept", id), 72'(v), 72'(0));
      if (hold_chk[id]) chk($sformatf("u%0d.hold_in_gap", id), {r1, r2, r3}, prev[id]);
    end
    if (v === 1'b1) begin
      sz = qsize(id);
      chk($sformatf("u%0d.window_expected", id), 72'(sz != 0), 72'(1));
      if (sz != 0) begin
        e = qpop(id);
        chk($sformatf("u%0d.row1", id), 72'(r1), 72'(e.r1));
        chk($sformatf("u%0d.row2", id), 72'(r2), 72'(e.r2));
        chk($sformatf("u%0d.row3", id), 72'(r3), 72'(e.r3));
        chk($sformatf("u%0d.frame_done", id), 72'(d), 72'(e.done));
        wins[id]++;
      end
    end else begin
      chk($sformatf("u%0d.done_without_valid", id), 72'(d), 72'(0));
    end
    if (d === 1'b1) dones[id]++;
    prev[id] = {r1, r2, r3};
  endtask

  always @(posedge clk) begin
    acc[0] = if4.iInValid;
    acc[1] = if28.iInValid;
    acc[2] = if3.iInValid;
  end

  always @(negedge clk) check_out(0, if4.oOutValid, if4.oFrameDone,
                                  if4.oWindowOutRow1, if4.oWindowOutRow2, if4.oWindowOutRow3);
  always @(negedge clk) check_out(1, if28.oOutValid, if28.oFrameDone,
                                  if28.oWindowOutRow1, if28.oWindowOutRow2, if28.oWindowOutRow3);
  always @(negedge clk) check_out(2, if3.oOutValid, if3.oFrameDone,
                                  if3.oWindowOutRow1, if3.oWindowOutRow2, if3.oWindowOutRow3);

  initial begin
    rst_n  = 1'b0;
    rst4_n = 1'b0;
    if4.iInValid = 1'b0;  if4.iPixel = '0;
    if28.iInValid = 1'b0; if28.iPixel = '0;
    if3.iInValid = 1'b0;  if3.iPixel = '0;
    for (int i = 0; i < 3; i++) model_reset(i);

    // Reset state of all instances.
    #23;
    chk("rst.u4.rows",  {if4.oWindowOutRow1, if4.oWindowOutRow2, if4.oWindowOutRow3}, '0);
    chk("rst.u4.flags", 72'({if4.oOutValid, if4.oFrameDone}), 72'(0));
    chk("rst.u28.rows", {if28.oWindowOutRow1, if28.oWindowOutRow2, if28.oWindowOutRow3}, '0);
    chk("rst.u28.flags", 72'({if28.oOutValid, if28.oFrameDone}), 72'(0));
    chk("rst.u3.rows",  {if3.oWindowOutRow1, if3.oWindowOutRow2, if3.oWindowOutRow3}, '0);
    chk("rst.u3.flags", 72'({if3.oOutValid, if3.oFrameDone}), 72'(0));
    @(negedge clk);
    rst_n  = 1'b1;
    rst4_n = 1'b1;
    idle(2);

    // 4x4: frame A (4r+c) immediately followed by frame B (100+4r+c).
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) drive(0, 1'b1, 8'(4*r + c));
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) drive(0, 1'b1, 8'(100 + 4*r + c));
    idle(3);
    chk("u4.windows_two_frames", 72'(wins[0]), 72'(8));
    chk("u4.done_two_frames", 72'(dones[0]), 72'(2));

    // 4x4 with a gap cycle after every pixel; outputs must hold across gaps.
    hold_chk[0] = 1'b1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        drive(0, 1'b1, 8'(4*r + c));
        drive(0, 1'b0, 8'hEE);
      end
    idle(3);
    hold_chk[0] = 1'b0;
    chk("u4.windows_gap_frame", 72'(wins[0]), 72'(12));

    // Partial frame up to (2,2), then an asynchronous reset mid-row 2.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) drive(0, 1'b1, 8'(4*r + c));
    for (int c = 0; c < 3; c++) drive(0, 1'b1, 8'(8 + c));
    if4.iInValid = 1'b0;
    @(negedge clk);
    #1;
    chk("u4.valid_before_reset", 72'(if4.oOutValid), 72'(1));
    rst4_n = 1'b0;
    #1;
    chk("u4.rows_async_reset", {if4.oWindowOutRow1, if4.oWindowOutRow2, if4.oWindowOutRow3}, '0);
    chk("u4.flags_async_reset", 72'({if4.oOutValid, if4.oFrameDone}), 72'(0));
    chk("u4.no_pending_at_reset", 72'(qsize(0)), 72'(0));
    model_reset(0);
    @(negedge clk);
    rst4_n = 1'b1;
    idle(1);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) drive(0, 1'b1, 8'(4*r + c));
    idle(3);
    chk("u4.windows_after_restart", 72'(wins[0]), 72'(17));
    chk("u4.queue_drained", 72'(qsize(0)), 72'(0));

    // 28x28 boundary scan with random pixels.
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) drive(1, 1'b1, 8'($urandom_range(0, 255)));
    idle(3);
    chk("u28.windows", 72'(wins[1]), 72'(676));
    chk("u28.done_pulses", 72'(dones[1]), 72'(1));
    chk("u28.queue_drained", 72'(qsize(1)), 72'(0));

    // 3x3 minimum image, pixels 1..9: exactly one window with frame done.
    for (int i = 1; i <= 9; i++) drive(2, 1'b1, 8'(i));
    idle(3);
    chk("u3.windows", 72'(wins[2]), 72'(1));
    chk("u3.done_pulses", 72'(dones[2]), 72'(1));
    chk("u3.queue_drained", 72'(qsize(2)), 72'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/window_gen3x3.md
Name: window_gen3x3

Overview:
- Streaming 3x3 window generator; the producer end of the window interface consumed by the conv3x3 kernel.
- Accepts a raster-order pixel stream, one pixel per valid cycle, and buffers two image lines.
- Emits one 3x3 window per accepted pixel once a full valid-convolution window exists: no padding, stride 1.
- Sits between the input feature-map source and each conv3x3 instance.

Parameters:
- WI, 8, pixel width in bits.
- IMG_W, 28, image width in pixels (>=3).
- IMG_H, 28, image height in lines (>=3).
- CW, 5, column/row counter width; must hold max(IMG_W, IMG_H)-1.

Ports:
- iClk  input  1  clock, rising edge.
- iRsn  input  1  asynchronous active-low reset.
- iInValid  input  1  iPixel valid this cycle; no back-pressure.
- iPixel  input  WI  pixel, raster order (row-major, left to right).
- oOutValid  output  1  window outputs valid this cycle.
- oWindowOutRow1  output  3*WI  top row (line r-2); bits [3WI-1 -: WI] = left column (c-2), bits [WI-1:0] = right column (c).
- oWindowOutRow2  output  3*WI  middle row (line r-1), same packing.
- oWindowOutRow3  output  3*WI  bottom row (line r), same packing.
- oFrameDone  output  1  one-cycle pulse, coincident with the last window of a frame.

Behaviour:
- Reset (iRsn=0, asynchronous):
  - col=0, row=0.
  - oOutValid=0, oFrameDone=0, all window registers and outputs = 0.
  - Line-buffer storage is not reset; its contents are masked by the row gating below.
- Only accepted pixels (iInValid=1) advance any state. With iInValid=0, all registers hold, oOutValid=0, oFrameDone=0, and the window outputs keep their last value.
- Per accepted pixel p at position (row, col):
  - Column taps: top = line buffer B output (pixel at row-2, col); mid = line buffer A output (row-1, col); bot = p.
  - Window registers shift left one column; the new column {top, mid, bot} enters the right slot (c).
  - Line A writes p and returns pixel (row-1, col). Line B writes line A's old output and returns (row-2, col). Each is a depth-IMG_W delay advanced only on accept.
  - oOutValid <= (row>=2 && col>=2), registered, so the window appears one cycle after its completing pixel.
  - oFrameDone <= (row==IMG_H-1 && col==IMG_W-1).
- Counters:
  - col increments and wraps IMG_W-1 -> 0; at that wrap, row increments.
  - row wraps IMG_H-1 -> 0. The next frame starts immediately, with no idle cycle required.
- Window count: exactly (IMG_W-2)*(IMG_H-2) windows per frame.
  - No valid output at col 0/1 of any row, or anywhere in rows 0/1.
  - Stale columns carried across a row boundary sit in the window only at col 0/1, which are masked.
- Back-to-back frames: frame N+1 rows 0/1 produce no windows. The line buffers still hold frame N data; this is correct because gating is by row.
- Reset mid-frame: all counters return to 0 and the next accepted pixel is treated as (0,0). No partial window from the aborted frame is ever emitted.
- Widths: pure data movement, no arithmetic on pixel values. Pixels are passed bit-exact (sign-agnostic).

Decomposition:
- Shared package/header: WI, IMG_W, IMG_H, derived CW (clog2), and the window packing order (left column = MSB slice). conv3x3 and this block must agree on the packing.
- One sub-module: line_buffer (parameters WI, DEPTH). It is a single-line delay with enable, implemented as a circular RAM with a read-before-write pointer, and is instantiated twice (A, B).
- Top level holds the counters, the 3x3 window shift registers, and the valid/frame-done flops.

Test Plan:
- IMG_W=4, IMG_H=4, pixel = 4r+c, continuous valid -> 4 windows.
  - First, one cycle after pixel 10: Row1={0,1,2}, Row2={4,5,6}, Row3={8,9,10}.
  - Last: Row1={5,6,7}, Row2={9,10,11}, Row3={13,14,15}, with oFrameDone=1 on that cycle only.
- Same image with iInValid toggling 1-0-1-0 (gaps) -> identical window sequence. oOutValid never high on gap-following cycles without an accept, and outputs hold during gaps.
- Two frames back-to-back, frame 2 pixel = 100+4r+c -> 8 windows total. Frame 2's first window is Row1={100,101,102}, Row2={104,105,106}, Row3={108,109,110}; no window mixes frame 1 data.
- Boundary scan with IMG_W=IMG_H=28 -> 676 windows. oOutValid is never asserted for col<2 or row<2 (checked against a counter-based scoreboard).
- Assert iRsn low for 1 cycle mid-row 2 -> outputs go 0 immediately (asynchronously). Restart from (0,0) yields the same first window as a clean frame.
- Minimum size IMG_W=IMG_H=3, pixels 1..9 -> exactly one window Row1={1,2,3}, Row2={4,5,6}, Row3={7,8,9}, with oFrameDone=1 on the same cycle.
